// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and sizing helpers for the streaming FC neuron
package fc_pkg;

   typedef enum logic [1:0] {ACC, DRAIN, OUT} fc_state_t;

   // Accumulator width: full product, one bit per input doubling, one for the bias.
   function automatic int fc_acc_w(input int width, input int n_in);
      return 2 * width + $clog2(n_in) + 1;
   endfunction

   function automatic int fc_beats(input int n_in, input int lanes);
      return n_in / lanes;
   endfunction

   function automatic int fc_sum_w(input int width, input int lanes);
      return 2 * width + $clog2(lanes);
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// rtl/fc_mac_lane.sv - one signed WIDTH x WIDTH multiplier with registered product
module fc_mac_lane #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   output logic signed [2*WIDTH-1:0] p
);

   always_ff @(posedge clk) begin
      if (rst) begin
         p <= '0;
      end else if (en) begin
         p <= (2*WIDTH)'(a) * (2*WIDTH)'(b);
      end
   end

endmodule

// File: rtl/fc_neuron_stream.sv
// rtl/fc_neuron_stream.sv - LANES-wide sequential FC neuron with bias preload and held output
// Build option FC_RELU_EN: clamp negative results to zero at the output stage.
module fc_neuron_stream
   import fc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IN    = 128,
   parameter int LANES = 4,
   parameter int ACC_W = fc_acc_w(WIDTH, IN)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic signed [WIDTH-1:0]   s_x [0:LANES-1],
   input  logic signed [WIDTH-1:0]   s_w [0:LANES-1],
   input  logic signed [2*WIDTH-1:0] s_bias,
   input  logic                      s_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic signed [ACC_W-1:0]   m_data,
   output logic                      err
);

   localparam int BEATS = fc_beats(IN, LANES);
   localparam int SUM_W = fc_sum_w(WIDTH, LANES);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

   fc_state_t                 state;
   logic [CNT_W-1:0]          cnt;
   logic                      accept;
   logic                      beat_first;
   logic                      beat_final;
   logic signed [2*WIDTH-1:0] prod [0:LANES-1];
   logic                      p_valid;
   logic                      p_first;
   logic                      p_final;
   logic signed [2*WIDTH-1:0] p_bias;
   logic                      a_final;
   logic signed [SUM_W-1:0]   lane_sum;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   out_val;

   assign accept     = s_valid && s_ready;
   assign beat_first = (cnt == '0);
   assign beat_final = (cnt == CNT_LAST);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fc_mac_lane #(.WIDTH(WIDTH)) u_lane (
         .clk (clk),
         .rst (rst),
         .en  (accept),
         .a   (s_x[g]),
         .b   (s_w[g]),
         .p   (prod[g])
      );
   end

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_sum = lane_sum + SUM_W'(prod[i]);
      end
   end

   // Tags and bias travel alongside the registered products so stage A sees a consistent beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_valid <= 1'b0;
         p_first <= 1'b0;
         p_final <= 1'b0;
         p_bias  <= '0;
         a_final <= 1'b0;
         acc     <= '0;
      end else begin
         p_valid <= accept;
         if (accept) begin
            p_first <= beat_first;
            p_final <= beat_final;
            if (beat_first) begin
               p_bias <= s_bias;
            end
         end
         a_final <= p_valid && p_final;
         if (p_valid) begin
            if (p_first) begin
               acc <= ACC_W'(p_bias) + ACC_W'(lane_sum);
            end else begin
               acc <= acc + ACC_W'(lane_sum);
            end
         end
      end
   end

`ifdef FC_RELU_EN
   assign out_val = acc[ACC_W-1] ? '0 : acc;
`else
   assign out_val = acc;
`endif

   // The counter alone closes the frame; s_last is only compared against it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ACC;
         s_ready <= 1'b1;
         m_valid <= 1'b0;
         m_data  <= '0;
         err     <= 1'b0;
         cnt     <= '0;
      end else begin
         if (accept) begin
            cnt <= beat_final ? '0 : cnt + CNT_W'(1);
            if (s_last != beat_final) begin
               err <= 1'b1;
            end
         end
         case (state)
            ACC: begin
               if (accept && beat_final) begin
                  state   <= DRAIN;
                  s_ready <= 1'b0;
               end
            end
            DRAIN: begin
               if (a_final) begin
                  state   <= OUT;
                  m_valid <= 1'b1;
                  m_data  <= out_val;
               end
            end
            OUT: begin
               if (m_ready) begin
                  state   <= ACC;
                  m_valid <= 1'b0;
                  s_ready <= 1'b1;
                  cnt     <= '0;
               end
            end
            default: begin
               state   <= ACC;
               s_ready <= 1'b1;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fc_neuron_stream.md
# fc_neuron_stream

Sequential, parametrised successor to the fully-unrolled FC neuron. It accepts `LANES` activation/weight pairs per beat over a valid/ready stream and multiplies them in `LANES` parallel MAC lanes. It accumulates one output neuron across `IN/LANES` beats with a bias preload, then presents the result, optionally ReLU-clamped, on a held output handshake. It sits between the activation buffer and the next layer's input stream, replacing the combinational booth/adder-tree neuron where area matters more than latency.

## Interface
- `WIDTH`, 8: signed width of activations, weights and half the product width.
- `IN`, 128: inputs per neuron. Must be a multiple of `LANES`.
- `LANES`, 4: activation/weight pairs consumed per beat. Power of two, at least 1.
- `ACC_W`, `2*WIDTH+$clog2(IN)+1`: signed accumulator and output width.
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `s_valid`, in, 1: input beat valid.
- `s_ready`, out, 1: block accepts a beat.
- `s_x`, in, `WIDTH` x `[0:LANES-1]`: signed activations.
- `s_w`, in, `WIDTH` x `[0:LANES-1]`: signed weights.
- `s_bias`, in, `2*WIDTH`: signed bias. Sampled on the first beat of a frame only.
- `s_last`, in, 1: producer's end-of-frame marker. Checked, not trusted.
- `m_valid`, out, 1: result valid.
- `m_ready`, in, 1: consumer accepts the result.
- `m_data`, out, `ACC_W`: signed neuron result.
- `err`, out, 1: sticky framing error.

## Operation
- Beat accepted when `s_valid && s_ready`.
- Beat counter `cnt` runs over 0..`IN/LANES-1`. The counter alone defines the frame boundary.
- Stage P (multiply): on acceptance, register `LANES` signed products of `2*WIDTH` bits each, plus tags `first` (`cnt==0`) and `final` (`cnt==IN/LANES-1`).
- Stage A (accumulate): sum the lanes to `2*WIDTH+$clog2(LANES)` bits and sign-extend to `ACC_W`.
  - If `first`: `acc <= sext(bias) + lane_sum`.
  - Otherwise: `acc <= acc + lane_sum`.
  - `ACC_W` is sized so overflow is impossible. No saturation logic.
- Stage O: when the Stage-A beat is `final`, load `m_data` and set `m_valid`.
- FSM states:
  - `ACC`: `s_ready=1`. On acceptance of the final beat, go to `DRAIN`.
  - `DRAIN`: `s_ready=0`. Wait for the final beat to reach Stage O, then go to `OUT`.
  - `OUT`: `m_valid=1`, `s_ready=0`. On `m_valid && m_ready`, go to `ACC`, clear `m_valid`, and reset `cnt` to 0.
- Framing check: `err` sets and stays set until `rst` in either case below. The frame still closes on the counter.
  - `s_last` is 1 on an accepted non-final beat.
  - `s_last` is 0 on the accepted final beat.
- `IN==LANES`: every beat is both `first` and `final`. The bias is applied and the result is produced from that single beat.
- Reset values: `s_ready=1` (state `ACC`), `m_valid=0`, `m_data=0`, `err=0`, `cnt=0`, `acc=0`. Pipeline tags are cleared.
- Reset mid-frame: the partial accumulation and in-flight products are discarded. The next accepted beat is `first`.

## Timing
- Final beat accepted at edge k: products at edge k, accumulator at k+1, `m_data`/`m_valid` at k+2.
- Latency is 3 cycles from the final-beat acceptance cycle to the first cycle `m_valid` is high.
- `m_data` and `m_valid` hold stable while `m_ready=0`.
- `s_ready` rises in the cycle after the output handshake. There is no input/output overlap.
- Non-final beats may be accepted back-to-back, one per cycle.
- Frame period with no stalls is `IN/LANES + 3` cycles.

## Configuration
- `FC_RELU_EN` defined: Stage O loads `0` when `acc` is negative, otherwise `acc`. This matches the legacy neuron's ReLU output.
- `FC_RELU_EN` undefined: Stage O loads `acc` unmodified (signed). Use this for the final logits layer.

## Structure
- Package `fc_pkg` holds:
  - state enum `fc_state_t {ACC, DRAIN, OUT}`;
  - function `fc_acc_w(width, in)`;
  - localparam helpers for beat count and lane-sum width.
- Sub-module `fc_mac_lane` holds one signed `WIDTH x WIDTH` multiplier with a registered product. It is instantiated `LANES` times.
- The lane-sum tree and accumulator stay in the top module.

## Test plan
- IN=8, LANES=4, all x=1, w=1, bias=0, s_last on beat 1 -> m_data=8, m_valid high 3 cycles after beat 1, err=0.
- IN=8, LANES=4, x=1, w=-1, bias=0 -> m_data=0 with `FC_RELU_EN`, m_data=-8 without.
- IN=128, LANES=4, all x=-128, w=-128, bias=32767 -> m_data=2129919. No overflow at ACC_W=24.
- Result pending, m_ready held low 5 cycles -> m_data/m_valid stable, s_ready=0 throughout. Handshake in cycle 6, s_ready=1 in the next cycle.
- IN=8, LANES=4, s_last=1 on beat 0 and 0 on beat 1 -> err=1 after beat 0, result still produced after beat 1, err stays 1.
- rst pulsed after one accepted beat, then a full frame with x=2, w=3, bias=5 -> m_data=53. First-frame data is absent.
